// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder: function codes, funct/ALUOp
// constants, controller states and the decode helper.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    FUNC_ADD = 3'd0,
    FUNC_SUB = 3'd1,
    FUNC_AND = 3'd2,
    FUNC_OR  = 3'd3,
    FUNC_NOR = 3'd4,
    FUNC_SLT = 3'd5,
    FUNC_MUL = 3'd6,
    FUNC_ILL = 3'd7
  } func_e;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    func_e func;
    logic  illegal;
  } dec_t;

  // mul_en=0 makes the multiply funct fall through to the illegal code.
  function automatic dec_t decode_op(input logic [1:0] aluop,
                                     input logic [5:0] funct,
                                     input logic       mul_en);
    dec_t d;
    d.func    = FUNC_ILL;
    d.illegal = 1'b1;
    case (aluop)
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: begin d.func = FUNC_ADD; d.illegal = 1'b0; end
          FUNCT_SUB: begin d.func = FUNC_SUB; d.illegal = 1'b0; end
          FUNCT_AND: begin d.func = FUNC_AND; d.illegal = 1'b0; end
          FUNCT_OR:  begin d.func = FUNC_OR;  d.illegal = 1'b0; end
          FUNCT_NOR: begin d.func = FUNC_NOR; d.illegal = 1'b0; end
          FUNCT_SLT: begin d.func = FUNC_SLT; d.illegal = 1'b0; end
          FUNCT_MUL: begin
            if (mul_en) begin
              d.func    = FUNC_MUL;
              d.illegal = 1'b0;
            end
          end
          default: begin
            d.func    = FUNC_ILL;
            d.illegal = 1'b1;
          end
        endcase
      end
      ALUOP_SUB: begin d.func = FUNC_SUB; d.illegal = 1'b0; end
      ALUOP_ADD: begin d.func = FUNC_ADD; d.illegal = 1'b0; end
      default: begin
        d.func    = FUNC_ILL;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_mul_seq.sv
// Sequential shift-add multiplier: one partial-product step per cycle for
// WIDTH cycles after start; done flags the final step, product is its result.
module alu_ctrl_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done     = 1'b0;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      // Accumulator is WIDTH bits wide, so carries past the top bit drop out.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LAST_STEP) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  // The last step's sum is handed out combinationally so the controller can
  // register it on the same edge the step completes.
  assign product = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_ctrl_mc.sv
// ALU control decoder with valid/ready handshake and an optional multi-cycle
// multiply; the multiply path exists only when ALU_CTRL_MC_MUL_EN is defined.
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       instruction,
  input  logic [1:0]       ALUOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       func,
  output logic [WIDTH-1:0] product,
  output logic             illegal
);

`ifdef ALU_CTRL_MC_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  func_e            func_q, func_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] product_q, product_d;
  dec_t             dec;
  logic             accept;

`ifdef ALU_CTRL_MC_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_ctrl_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_product)
  );
`else
  logic unused_operands;
  assign unused_operands = ^{a, b};
`endif

  // Ready drops while reset is held even though the state already reads IDLE.
  assign in_ready  = !rst && ((state_q == ST_IDLE) ||
                              ((state_q == ST_HOLD) && out_ready));
  assign out_valid = (state_q == ST_HOLD);
  assign func      = func_q;
  assign product   = product_q;
  assign illegal   = illegal_q;

  always_comb begin
    dec       = decode_op(ALUOp, instruction, MUL_EN);
    accept    = in_valid && in_ready;
    state_d   = state_q;
    func_d    = func_q;
    illegal_d = illegal_q;
    product_d = product_q;
`ifdef ALU_CTRL_MC_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          func_d    = dec.func;
          illegal_d = dec.illegal;
          product_d = '0;
          state_d   = ST_HOLD;
`ifdef ALU_CTRL_MC_MUL_EN
          if (dec.func == FUNC_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end
`endif
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
`ifdef ALU_CTRL_MC_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          state_d   = ST_HOLD;
          product_d = mul_product;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      func_q    <= FUNC_ADD;
      illegal_q <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      illegal_q <= illegal_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: directed steps plus randomized requests
// compared against a table/arithmetic reference model.
module tb_alu_ctrl_mc;

  localparam int W = 32;
`ifdef ALU_CTRL_MC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   instruction;
  logic [1:0]   ALUOp;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   func;
  logic [W-1:0] product;
  logic         illegal;

  int checks   = 0;
  int failures = 0;

  alu_ctrl_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instruction(instruction),
    .ALUOp      (ALUOp),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .func       (func),
    .product    (product),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: opcode table plus full-width arithmetic product, truncated.
  function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [2:0] f, output logic ill,
                                output logic [W-1:0] p, output int lat);
    logic [63:0] full;
    f = 3'd7; ill = 1'b1; p = '0; lat = 1;
    if (op == 2'b01) begin
      f = 3'd1; ill = 1'b0;
    end else if (op == 2'b10) begin
      f = 3'd0; ill = 1'b0;
    end else if (op == 2'b00) begin
      case (fn)
        6'h20: begin f = 3'd0; ill = 1'b0; end
        6'h22: begin f = 3'd1; ill = 1'b0; end
        6'h24: begin f = 3'd2; ill = 1'b0; end
        6'h25: begin f = 3'd3; ill = 1'b0; end
        6'h27: begin f = 3'd4; ill = 1'b0; end
        6'h2A: begin f = 3'd5; ill = 1'b0; end
        6'h18: begin
          if (MUL_ON) begin
            full = 64'(av) * 64'(bv);
            f = 3'd6; ill = 1'b0; p = full[W-1:0]; lat = W + 1;
          end
        end
        default: begin f = 3'd7; ill = 1'b1; end
      endcase
    end
  endfunction

  // Presents one request (DUT must be ready), waits out the model latency and
  // checks the result. Returns at posedge+2 with the DUT in HOLD.
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ordy, output logic [2:0] ef,
                      output logic eill, output logic [W-1:0] ep);
    int lat;
    model(op, fn, av, bv, ef, eill, ep, lat);
    ALUOp = op; instruction = fn; a = av; b = bv;
    out_ready = ordy; in_valid = 1'b1;
    #1;
    chk("in_ready_at_accept", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; instruction = 6'($urandom);
    for (int i = 1; i < lat; i++) begin
      #1;
      chk("mul_busy_out_valid", out_valid, 0);
      chk("mul_busy_in_ready", in_ready, 0);
      cyc();
    end
    #1;
    chk("result_out_valid", out_valid, 1);
    chk("result_func", func, ef);
    chk("result_illegal", illegal, eill);
    chk("result_product", product, ep);
    $display("txn aluop=%b funct=%h a=%h b=%h -> func=%0d illegal=%b product=%h",
             op, fn, av, bv, func, illegal, product);
  endtask

  logic [2:0]   ef;
  logic         eill;
  logic [W-1:0] ep;
  logic [5:0]   fn_tab [8];
  bit           stray_valid;

  initial begin
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25;
    fn_tab[4] = 6'h27; fn_tab[5] = 6'h2A; fn_tab[6] = 6'h18; fn_tab[7] = 6'h3F;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instruction = '0; ALUOp = '0; a = '0; b = '0;
    #3;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_func", func, 0);
    chk("reset_product", product, 0);
    chk("reset_illegal", illegal, 0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("ready_after_reset", in_ready, 1);

    // sub: latency 1
    send(2'b00, 6'h22, $urandom, $urandom, 1'b1, ef, eill, ep);
    cyc();
    // 7*9 multiply
    send(2'b00, 6'h18, 32'd7, 32'd9, 1'b1, ef, eill, ep);
    cyc();
    // truncation
    send(2'b00, 6'h18, 32'hFFFF_FFFF, 32'd2, 1'b1, ef, eill, ep);
    cyc();

    // HOLD stalled by out_ready=0, then back-to-back add
    send(2'b00, 6'h24, $urandom, $urandom, 1'b0, ef, eill, ep);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_func", func, ef);
      chk("stall_illegal", illegal, eill);
      chk("stall_product", product, ep);
      chk("stall_in_ready", in_ready, 0);
    end
    send(2'b00, 6'h20, $urandom, $urandom, 1'b1, ef, eill, ep);
    cyc();

    // stalled multiply result stays put
    send(2'b00, 6'h18, $urandom, $urandom, 1'b0, ef, eill, ep);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("stall_mul_product", product, ep);
      chk("stall_mul_out_valid", out_valid, 1);
    end
    send(2'b00, 6'h3F, $urandom, $urandom, 1'b1, ef, eill, ep);
    cyc();
    send(2'b11, 6'h20, $urandom, $urandom, 1'b1, ef, eill, ep);
    cyc();
    send(2'b01, 6'h3F, $urandom, $urandom, 1'b1, ef, eill, ep);
    send(2'b10, 6'h22, $urandom, $urandom, 1'b1, ef, eill, ep);
    cyc();

    // reset in the middle of a multiply
    ALUOp = 2'b00; instruction = 6'h18; a = $urandom; b = $urandom;
    out_ready = 1'b1; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    #1;
    chk("midmul_rst_out_valid", out_valid, 0);
    chk("midmul_rst_product", product, 0);
    chk("midmul_rst_func", func, 0);
    chk("midmul_rst_illegal", illegal, 0);
    chk("midmul_rst_in_ready", in_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("midmul_ready_after_reset", in_ready, 1);
    stray_valid = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      cyc();
      if (out_valid !== 1'b0) stray_valid = 1'b1;
    end
    chk("midmul_no_stray_result", stray_valid, 0);
    send(2'b00, 6'h18, 32'd3, 32'd5, 1'b1, ef, eill, ep);
    cyc();

    // randomized requests, mixed idle gaps and back-to-back
    for (int n = 0; n < 24; n++) begin
      logic [1:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fn = fn_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      send(op, fn, $urandom, $urandom, 1'b1, ef, eill, ep);
      if ($urandom_range(0, 1) == 1) cyc();
    end
    cyc();
    #1;
    chk("final_idle_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
